// File: rtl/gyro_uart_framer_pkg.sv
// Shared types and constants for the gyro telemetry UART framer.
// Build option: GYRO_UART_FRAMER_CSUM_EN appends '*' plus a two-digit XOR checksum.
package gyro_uart_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned SAMPLE_W        = 16;
  localparam int unsigned FRAME_LEN_PLAIN = 25;
  localparam int unsigned FRAME_LEN_CSUM  = 28;
`ifdef GYRO_UART_FRAMER_CSUM_EN
  localparam int unsigned FRAME_LEN       = FRAME_LEN_CSUM;
`else
  localparam int unsigned FRAME_LEN       = FRAME_LEN_PLAIN;
`endif
  localparam int unsigned IDX_W           = $clog2(FRAME_LEN_CSUM);
  localparam int unsigned GAP_W           = 4;
  // Index of the last T hex digit; checksum covers bytes 0..this.
  localparam int unsigned LAST_DIGIT_IDX  = 22;

  localparam logic [BYTE_W-1:0] ASCII_X    = 8'h58;
  localparam logic [BYTE_W-1:0] ASCII_Y    = 8'h59;
  localparam logic [BYTE_W-1:0] ASCII_Z    = 8'h5A;
  localparam logic [BYTE_W-1:0] ASCII_T    = 8'h54;
  localparam logic [BYTE_W-1:0] ASCII_CR   = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF   = 8'h0A;
  localparam logic [BYTE_W-1:0] ASCII_STAR = 8'h2A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] x;
    logic [SAMPLE_W-1:0] y;
    logic [SAMPLE_W-1:0] z;
    logic [SAMPLE_W-1:0] t;
  } gyro_sample_t;

endpackage

// File: rtl/gyro_uart_framer_if.sv
// Byte handshake between the framer and UART_TX.
interface gyro_uart_framer_if;
  import gyro_uart_pkg::*;

  logic [BYTE_W-1:0] tx_data;
  logic              tx_load;
  logic              tx_ready;

  modport master (output tx_data, output tx_load, input tx_ready);
  modport slave  (input tx_data, input tx_load, output tx_ready);
endinterface

// File: rtl/gyro_uart_framer_hex_nibble_ascii.sv
// Converts a 4-bit value to its uppercase ASCII hex digit.
module hex_nibble_ascii
  import gyro_uart_pkg::*;
(
  input  logic [3:0]        nibble_i,
  output logic [BYTE_W-1:0] ascii_o
);

  // '0'-'9' start at 8'h30, 'A'-'F' at 8'h41 (8'h37 + 10).
  always_comb begin
    if (nibble_i < 4'd10) ascii_o = BYTE_W'(nibble_i) + 8'h30;
    else                  ascii_o = BYTE_W'(nibble_i) + 8'h37;
  end

endmodule

// File: rtl/gyro_uart_framer.sv
// Gyro telemetry framer: snapshots x/y/z/t on start and streams one ASCII hex
// line into UART_TX over its load/ready handshake.
// Build option: GYRO_UART_FRAMER_CSUM_EN adds "*HH" checksum before CR LF.
module gyro_uart_framer
  import gyro_uart_pkg::*;
#(
  parameter logic [7:0]  SEP        = 8'h2C,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                GCLK,
  input  logic                RST,
  input  logic                start,
  input  logic [SAMPLE_W-1:0] x_in,
  input  logic [SAMPLE_W-1:0] y_in,
  input  logic [SAMPLE_W-1:0] z_in,
  input  logic [SAMPLE_W-1:0] t_in,
  gyro_uart_framer_if.master  tx,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          drop_cnt
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  gyro_sample_t       hold_q, hold_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic               tx_load_q, tx_load_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [7:0]         drop_q, drop_d;
  logic [3:0]         nib_c;
  logic [BYTE_W-1:0]  nib_ascii_c;
  logic [BYTE_W-1:0]  sel_c;
`ifdef GYRO_UART_FRAMER_CSUM_EN
  logic [BYTE_W-1:0]  csum_q, csum_d;
  logic [3:0]         csum_nib_c;
  logic [BYTE_W-1:0]  csum_ascii_c;
`endif

  hex_nibble_ascii u_hex_data (.nibble_i(nib_c), .ascii_o(nib_ascii_c));

`ifdef GYRO_UART_FRAMER_CSUM_EN
  // High checksum digit goes out first, at the byte right after '*'.
  assign csum_nib_c = (idx_q == IDX_W'(LAST_DIGIT_IDX + 2)) ? csum_q[7:4] : csum_q[3:0];

  hex_nibble_ascii u_hex_csum (.nibble_i(csum_nib_c), .ascii_o(csum_ascii_c));
`endif

  // Pick the sample nibble addressed by the byte index, MSB nibble first.
  always_comb begin
    nib_c = 4'h0;
    case (idx_q)
      5'd1:  nib_c = hold_q.x[15:12];
      5'd2:  nib_c = hold_q.x[11:8];
      5'd3:  nib_c = hold_q.x[7:4];
      5'd4:  nib_c = hold_q.x[3:0];
      5'd7:  nib_c = hold_q.y[15:12];
      5'd8:  nib_c = hold_q.y[11:8];
      5'd9:  nib_c = hold_q.y[7:4];
      5'd10: nib_c = hold_q.y[3:0];
      5'd13: nib_c = hold_q.z[15:12];
      5'd14: nib_c = hold_q.z[11:8];
      5'd15: nib_c = hold_q.z[7:4];
      5'd16: nib_c = hold_q.z[3:0];
      5'd19: nib_c = hold_q.t[15:12];
      5'd20: nib_c = hold_q.t[11:8];
      5'd21: nib_c = hold_q.t[7:4];
      5'd22: nib_c = hold_q.t[3:0];
      default: nib_c = 4'h0;
    endcase
  end

  // Byte mux: tags, separators and line end override the hex digit.
  always_comb begin
    sel_c = nib_ascii_c;
    case (idx_q)
      5'd0:                 sel_c = ASCII_X;
      5'd6:                 sel_c = ASCII_Y;
      5'd12:                sel_c = ASCII_Z;
      5'd18:                sel_c = ASCII_T;
      5'd5, 5'd11, 5'd17:   sel_c = SEP;
`ifdef GYRO_UART_FRAMER_CSUM_EN
      5'd23:                sel_c = ASCII_STAR;
      5'd24, 5'd25:         sel_c = csum_ascii_c;
      5'd26:                sel_c = ASCII_CR;
      5'd27:                sel_c = ASCII_LF;
      5'd28, 5'd29, 5'd30, 5'd31: sel_c = 8'h00;
`else
      5'd23:                sel_c = ASCII_CR;
      5'd24:                sel_c = ASCII_LF;
      5'd25, 5'd26, 5'd27, 5'd28, 5'd29, 5'd30, 5'd31: sel_c = 8'h00;
`endif
      default:              sel_c = nib_ascii_c;
    endcase
  end

  // Next-state and registered-output logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    hold_d    = hold_q;
    tx_data_d = tx_data_q;
    tx_load_d = tx_load_q;
    done_d    = 1'b0;
    drop_d    = drop_q;
`ifdef GYRO_UART_FRAMER_CSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hold_d.x  = x_in;
          hold_d.y  = y_in;
          hold_d.z  = z_in;
          hold_d.t  = t_in;
          idx_d     = '0;
          tx_data_d = ASCII_X;
          tx_load_d = 1'b1;
          state_d   = ST_LOAD;
`ifdef GYRO_UART_FRAMER_CSUM_EN
          csum_d    = '0;
`endif
        end
      end
      ST_LOAD: begin
        if (tx.tx_ready) begin
          tx_load_d = 1'b0;
`ifdef GYRO_UART_FRAMER_CSUM_EN
          if (idx_q <= IDX_W'(LAST_DIGIT_IDX)) csum_d = csum_q ^ tx_data_q;
`endif
          if (idx_q == IDX_W'(FRAME_LEN - 1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            gap_d   = GAP_W'(GAP_CYCLES - 1);
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          tx_data_d = sel_c;
          tx_load_d = 1'b1;
          state_d   = ST_LOAD;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A start that arrives mid-frame is dropped and counted.
    if (start && (state_q != ST_IDLE) && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge GCLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      gap_q     <= '0;
      hold_q    <= '0;
      tx_data_q <= '0;
      tx_load_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= '0;
`ifdef GYRO_UART_FRAMER_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      hold_q    <= hold_d;
      tx_data_q <= tx_data_d;
      tx_load_q <= tx_load_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
`ifdef GYRO_UART_FRAMER_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign tx.tx_data = tx_data_q;
  assign tx.tx_load = tx_load_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_gyro_uart_framer.sv
// Self-checking bench for gyro_uart_framer with a string-level frame model.
module tb_gyro_uart_framer;

  localparam int GAP = 1;

  logic        GCLK = 1'b0;
  logic        RST  = 1'b1;
  logic        start = 1'b0;
  logic [15:0] x_in = '0, y_in = '0, z_in = '0, t_in = '0;
  logic        busy, frame_done;
  logic [7:0]  drop_cnt;

  gyro_uart_framer_if tx_if ();

  gyro_uart_framer #(.SEP(8'h2C), .GAP_CYCLES(GAP)) dut (
    .GCLK      (GCLK),
    .RST       (RST),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .t_in      (t_in),
    .tx        (tx_if),
    .busy      (busy),
    .frame_done(frame_done),
    .drop_cnt  (drop_cnt)
  );

  always #5 GCLK = ~GCLK;

  int errors = 0;
  int checks = 0;
  int exp_drop = 0;
  byte unsigned exp_q[$];

  function automatic byte unsigned hexc(input int v);
    return (v < 10) ? 8'(8'h30 + v) : 8'(8'h41 + v - 10);
  endfunction

  // Expected line: tag + 4 hex digits per field, ',' between, optional checksum, CR LF.
  function automatic void build_frame(input logic [15:0] x, y, z, t);
    byte unsigned tags[4];
    int vals[4];
    byte unsigned cs;
    tags = '{8'h58, 8'h59, 8'h5A, 8'h54};
    vals = '{int'(x), int'(y), int'(z), int'(t)};
    exp_q.delete();
    for (int f = 0; f < 4; f++) begin
      if (f > 0) exp_q.push_back(8'h2C);
      exp_q.push_back(tags[f]);
      for (int n = 3; n >= 0; n--) exp_q.push_back(hexc((vals[f] >> (4 * n)) & 15));
    end
`ifdef GYRO_UART_FRAMER_CSUM_EN
    cs = 8'h00;
    foreach (exp_q[i]) cs = cs ^ exp_q[i];
    exp_q.push_back(8'h2A);
    exp_q.push_back(hexc(int'(cs) >> 4));
    exp_q.push_back(hexc(int'(cs) & 15));
`else
    cs = 8'h00;
`endif
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic start_frame(input logic [15:0] x, y, z, t);
    build_frame(x, y, z, t);
    x_in = x; y_in = y; z_in = z; t_in = t;
    tx_if.tx_ready = 1'b1;
    start = 1'b1;
    @(negedge GCLK);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || tx_if.tx_load !== 1'b1 || tx_if.tx_data !== 8'h58 ||
        frame_done !== 1'b0 || drop_cnt !== 8'(exp_drop)) begin
      errors++;
      $display("FAIL frame_start: busy=%b load=%b data=%h done=%b drop=%0d, expected 1 1 58 0 %0d",
               busy, tx_if.tx_load, tx_if.tx_data, frame_done, drop_cnt, exp_drop);
    end
  endtask

  // Streams one frame; returns at the negedge where frame_done is high.
  task automatic stream_frame(input int stall_k, input int stall_len, input bit rnd_ready,
                              input int drop_mode, output int done_edge);
    int k, e, stalled, last_acc;
    bit exp_load, acc;
    k = 0; e = 0; stalled = 0; last_acc = -GAP; done_edge = -1;
    while (done_edge < 0 && e < 4000) begin
      exp_load = (e >= last_acc + GAP);
      checks++;
      if (tx_if.tx_load !== exp_load || busy !== 1'b1 ||
          (exp_load && tx_if.tx_data !== exp_q[k])) begin
        errors++;
        $display("FAIL stream byte %0d edge %0d: load=%b busy=%b data=%h, expected load=%b busy=1 data=%h",
                 k, e, tx_if.tx_load, busy, tx_if.tx_data, exp_load, exp_q[k]);
      end
      if (exp_load && k == stall_k && stalled < stall_len) begin
        tx_if.tx_ready = 1'b0;
        stalled++;
      end else begin
        tx_if.tx_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      start = (drop_mode == 1 && (e == 9 || e == 13 || e == 17)) ||
              (drop_mode == 2 && !tx_if.tx_ready);
      if (start && exp_drop < 255) exp_drop++;
      {x_in, y_in} = $urandom();
      {z_in, t_in} = $urandom();
      acc = exp_load && tx_if.tx_ready;
      @(negedge GCLK);
      e++;
      if (acc) begin
        last_acc = e;
        k++;
      end
      checks++;
      if (frame_done !== (acc && k == exp_q.size()) || drop_cnt !== 8'(exp_drop)) begin
        errors++;
        $display("FAIL stream edge %0d: frame_done=%b drop=%0d, expected %b %0d",
                 e, frame_done, drop_cnt, (acc && k == exp_q.size()), exp_drop);
      end
      if (acc && k == exp_q.size()) done_edge = e;
    end
    start = 1'b0;
    tx_if.tx_ready = 1'b1;
    checks++;
    if (done_edge < 0) begin
      errors++;
      $display("FAIL stream timeout: %0d of %0d bytes accepted", k, exp_q.size());
    end else if (busy !== 1'b0 || tx_if.tx_load !== 1'b0) begin
      errors++;
      $display("FAIL frame_end: busy=%b load=%b, expected 0 0", busy, tx_if.tx_load);
    end
  endtask

  task automatic idle_check(input string name);
    @(negedge GCLK);
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0 || tx_if.tx_load !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: done=%b busy=%b load=%b, expected 0 0 0",
               name, frame_done, busy, tx_if.tx_load);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tx_if.tx_ready = 1'b1;
    repeat (2) @(negedge GCLK);
    checks++;
    if (tx_if.tx_data !== 8'h00 || tx_if.tx_load !== 1'b0 || busy !== 1'b0 ||
        frame_done !== 1'b0 || drop_cnt !== 8'h00) begin
      errors++;
      $display("FAIL reset: data=%h load=%b busy=%b done=%b drop=%0d, expected 00 0 0 0 0",
               tx_if.tx_data, tx_if.tx_load, busy, frame_done, drop_cnt);
    end
    RST = 1'b0;
    exp_drop = 0;
    idle_check("post_reset");
  endtask

  task automatic test_basic();
    int de;
    start_frame(16'h1A2B, 16'h00FF, 16'hFFFF, 16'h0123);
    stream_frame(-1, 0, 1'b0, 0, de);
    checks++;
    if (de !== 2 * exp_q.size() - 1) begin
      errors++;
      $display("FAIL basic_last_edge: got %0d expected %0d", de, 2 * exp_q.size() - 1);
    end
    idle_check("basic");
  endtask

  task automatic test_stall();
    int de;
    start_frame(16'h1A2B, 16'h00FF, 16'hFFFF, 16'h0123);
    stream_frame(7, 10, 1'b0, 0, de);
    checks++;
    if (de !== 2 * exp_q.size() - 1 + 10) begin
      errors++;
      $display("FAIL stall_last_edge: got %0d expected %0d", de, 2 * exp_q.size() + 9);
    end
    idle_check("stall");
  endtask

  task automatic test_drops();
    int de;
    start_frame(16'hBEEF, 16'h1234, 16'h5678, 16'h9ABC);
    stream_frame(-1, 0, 1'b0, 1, de);
    checks++;
    if (drop_cnt !== 8'd3) begin
      errors++;
      $display("FAIL drop_three: got %0d expected 3", drop_cnt);
    end
    idle_check("drops");
    start_frame(16'hCAFE, 16'h0F0F, 16'hA5A5, 16'h7E57);
    stream_frame(0, 300, 1'b0, 2, de);
    checks++;
    if (drop_cnt !== 8'd255) begin
      errors++;
      $display("FAIL drop_saturate: got %0d expected 255", drop_cnt);
    end
    idle_check("drops_sat");
  endtask

  task automatic test_mid_reset();
    int de;
    start_frame(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    for (int e = 0; e < 19; e++) begin
      start = (e == 5);
      @(negedge GCLK);
    end
    start = 1'b0;
    RST = 1'b1;
    @(negedge GCLK);
    RST = 1'b0;
    exp_drop = 0;
    checks++;
    if (tx_if.tx_load !== 1'b0 || busy !== 1'b0 || drop_cnt !== 8'h00 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: load=%b busy=%b drop=%0d done=%b, expected 0 0 0 0",
               tx_if.tx_load, busy, drop_cnt, frame_done);
    end
    repeat (4) idle_check("mid_reset");
    start_frame(16'h5555, 16'h6666, 16'h7777, 16'h8888);
    stream_frame(-1, 0, 1'b0, 0, de);
    idle_check("after_reset_frame");
  endtask

  task automatic test_back_to_back();
    int de;
    start_frame(16'hFACE, 16'h0000, 16'h8001, 16'h00A0);
    stream_frame(-1, 0, 1'b0, 0, de);
    start_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    stream_frame(-1, 0, 1'b0, 0, de);
    checks++;
    if (de !== 2 * exp_q.size() - 1 || drop_cnt !== 8'(exp_drop)) begin
      errors++;
      $display("FAIL back_to_back: last_edge=%0d drop=%0d, expected %0d %0d",
               de, drop_cnt, 2 * exp_q.size() - 1, exp_drop);
    end
    idle_check("back_to_back");
  endtask

  task automatic test_random();
    int de;
    for (int i = 0; i < 4; i++) begin
      start_frame(16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()));
      stream_frame(-1, 0, 1'b1, 0, de);
      idle_check("random");
    end
  endtask

  task automatic test_zero_frame();
    int de;
    start_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    stream_frame(-1, 0, 1'b0, 0, de);
    checks++;
    if (de !== 2 * exp_q.size() - 1) begin
      errors++;
      $display("FAIL zero_last_edge: got %0d expected %0d", de, 2 * exp_q.size() - 1);
    end
    idle_check("zero");
  endtask

  initial begin
    tx_if.tx_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_drops();
    test_mid_reset();
    test_back_to_back();
    test_random();
    test_zero_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
